// File: rtl/handshake_pkg.sv
// Shared types for the request-confirm handshake initiator.
// Holds the FSM state encoding, word width and phase-counter sizing.
package handshake_pkg;

  localparam int WORD_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_CONF,
    S_CHECK,
    S_GAP
  } state_t;

  // Down-counters are loaded with N-1, so they need clog2 of the
  // largest phase length, with a floor of one bit.
  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/req_confirm_initiator_fifo.sv
// Small synchronous FIFO with a registered count; pop returns the head
// on the same edge. Ports: push/push_data in, pop in, head/full/empty out.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_acc;
  logic             pop_acc;

  // Full blocks pushes even when a pop lands on the same edge.
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_acc = push && !full;
  assign pop_acc  = pop && !empty;
  assign head     = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/req_confirm_initiator.sv
// Transmit side of the req/din/confirm handshake: queues words, then
// drives req, din and a timed confirm, and checks the dout_right echo.
// Ports: push_* upstream queue, req/din/confirm to responder,
// dout_right echo in, busy/sent_cnt/err status (all registered).
import handshake_pkg::*;

module req_confirm_initiator #(
  parameter int DEPTH      = 4,
  parameter int REQ_SETUP  = 2,
  parameter int DATA_SETUP = 2,
  parameter int CONF_HOLD  = 2,
  parameter int GAP        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [WORD_W-1:0] push_data,
  output logic              push_ready,
  output logic              req,
  output logic [WORD_W-1:0] din,
  output logic              confirm,
  input  logic [WORD_W-1:0] dout_right,
  output logic              busy,
  output logic [7:0]        sent_cnt,
  output logic              err
);

  localparam int CNT_W =
    cnt_width(REQ_SETUP, DATA_SETUP, CONF_HOLD, GAP);

  localparam logic [CNT_W-1:0] LD_REQ  = CNT_W'(REQ_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_DATA = CNT_W'(DATA_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_CONF = CNT_W'(CONF_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(GAP - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              req_q, req_d;
  logic [WORD_W-1:0] din_q, din_d;
  logic              confirm_q, confirm_d;
  logic              busy_q, busy_d;
  logic [7:0]        sent_q, sent_d;
  logic              err_q, err_d;

  logic              pop;
  logic [WORD_W-1:0] head;
  logic              full;
  logic              empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_valid),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    sent_d  = sent_q;
    err_d   = err_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_REQ;
          cnt_d   = LD_REQ;
        end
      end
      S_REQ: begin
        if (cnt_q == '0) begin
          pop     = 1'b1;
          word_d  = head;
          state_d = S_DATA;
          cnt_d   = LD_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          state_d = S_CONF;
          cnt_d   = LD_CONF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CONF: begin
        if (cnt_q == '0) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CHECK: begin
        sent_d = sent_q + 8'd1;
        if (dout_right != word_q) err_d = 1'b1;
        // Queued words follow back-to-back under the same req.
        if (!empty) begin
          pop     = 1'b1;
          word_d  = head;
          state_d = S_DATA;
          cnt_d   = LD_DATA;
        end else begin
          state_d = S_GAP;
          cnt_d   = LD_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so they come straight off flops.
  always_comb begin
    req_d     = (state_d == S_REQ)  || (state_d == S_DATA) ||
                (state_d == S_CONF) || (state_d == S_CHECK);
    din_d     = ((state_d == S_DATA) || (state_d == S_CONF) ||
                 (state_d == S_CHECK)) ? word_d : '0;
    confirm_d = (state_d == S_CONF);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      word_q    <= '0;
      req_q     <= 1'b0;
      din_q     <= '0;
      confirm_q <= 1'b0;
      busy_q    <= 1'b0;
      sent_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      req_q     <= req_d;
      din_q     <= din_d;
      confirm_q <= confirm_d;
      busy_q    <= busy_d;
      sent_q    <= sent_d;
      err_q     <= err_d;
    end
  end

  assign push_ready = !full;
  assign req        = req_q;
  assign din        = din_q;
  assign confirm    = confirm_q;
  assign busy       = busy_q;
  assign sent_cnt   = sent_q;
  assign err        = err_q;

endmodule

// File: tb/tb_req_confirm_initiator.sv
// Directed bench for req_confirm_initiator with immediate assertions.
// Echo is looped back from din, optionally corrupted by an XOR mask.
module tb_req_confirm_initiator;

  logic       clk = 1'b0;
  logic       rst;
  logic       push_valid;
  logic [3:0] push_data;
  logic       push_ready;
  logic       req;
  logic [3:0] din;
  logic       confirm;
  logic [3:0] dout_right;
  logic       busy;
  logic [7:0] sent_cnt;
  logic       err;
  logic [3:0] mask;

  int total = 0;
  int bad   = 0;

  int         conf_rises = 0;
  int         req_rises  = 0;
  logic       conf_prev  = 1'b0;
  logic       req_prev   = 1'b0;
  logic [3:0] dlog[$];

  always #5 clk = ~clk;

  assign dout_right = din ^ mask;

  req_confirm_initiator dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .req        (req),
    .din        (din),
    .confirm    (confirm),
    .dout_right (dout_right),
    .busy       (busy),
    .sent_cnt   (sent_cnt),
    .err        (err)
  );

  always @(negedge clk) begin
    if (confirm && !conf_prev) begin
      conf_rises = conf_rises + 1;
      dlog.push_back(din);
    end
    if (req && !req_prev) req_rises = req_rises + 1;
    conf_prev = confirm;
    req_prev  = req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [3:0] d);
    int n;
    n = 0;
    push_valid = 1'b1;
    push_data  = d;
    while (push_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("push_ready_wait", push_ready, 1);
    tick();
    push_valid = 1'b0;
  endtask

  task automatic wait_sent(input logic [7:0] tgt);
    int n;
    n = 0;
    while (sent_cnt !== tgt && n < 200) begin
      tick();
      n++;
    end
    check("wait_sent", sent_cnt, tgt);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    while (busy !== 1'b0 && n < 3000) begin
      tick();
      n++;
    end
    check("wait_idle", busy, 0);
  endtask

  int c0;
  int r0;
  int q0;
  int n;

  initial begin
    rst        = 1'b1;
    push_valid = 1'b0;
    push_data  = 4'h0;
    mask       = 4'h0;
    tick();
    tick();
    check("rst_req", req, 0);
    check("rst_din", din, 0);
    check("rst_confirm", confirm, 0);
    check("rst_busy", busy, 0);
    check("rst_sent", sent_cnt, 0);
    check("rst_err", err, 0);
    check("rst_ready", push_ready, 1);
    #2 rst = 1'b0;
    tick();

    // Single word, cycle by cycle.
    push_word(4'h3);
    check("t1_idle_req", req, 0);
    tick();
    check("t1_req_r1", req, 1);
    check("t1_din_r1", din, 0);
    check("t1_busy", busy, 1);
    tick();
    check("t1_din_r2", din, 0);
    check("t1_conf_r2", confirm, 0);
    tick();
    check("t1_din_d1", din, 3);
    check("t1_conf_d1", confirm, 0);
    tick();
    check("t1_din_d2", din, 3);
    check("t1_conf_d2", confirm, 0);
    tick();
    check("t1_conf_c1", confirm, 1);
    check("t1_din_c1", din, 3);
    tick();
    check("t1_conf_c2", confirm, 1);
    tick();
    check("t1_conf_chk", confirm, 0);
    check("t1_req_chk", req, 1);
    check("t1_din_chk", din, 3);
    tick();
    check("t1_req_gap", req, 0);
    check("t1_din_gap", din, 0);
    check("t1_sent", sent_cnt, 1);
    check("t1_err", err, 0);
    check("t1_busy_gap", busy, 1);
    tick();
    check("t1_busy_idle", busy, 0);

    // Burst of three under one req.
    c0 = conf_rises;
    r0 = req_rises;
    q0 = dlog.size();
    push_word(4'h3);
    push_word(4'h5);
    push_word(4'h4);
    wait_sent(8'd4);
    wait_idle();
    check("t2_confs", conf_rises - c0, 3);
    check("t2_reqs", req_rises - r0, 1);
    check("t2_w0", dlog[q0], 3);
    check("t2_w1", dlog[q0+1], 5);
    check("t2_w2", dlog[q0+2], 4);
    check("t2_err", err, 0);

    // Fill the FIFO while the first word is on the wire.
    c0 = conf_rises;
    q0 = dlog.size();
    push_word(4'h1);
    n = 0;
    while (din !== 4'h1 && n < 50) begin
      tick();
      n++;
    end
    check("t3_data_entry", din, 1);
    push_valid = 1'b1;
    push_data  = 4'h6;
    tick();
    push_data  = 4'h7;
    tick();
    push_data  = 4'h8;
    tick();
    push_data  = 4'h9;
    tick();
    check("t3_full_ready", push_ready, 0);
    push_data  = 4'hA;
    tick();
    check("t3_after_pop_ready", push_ready, 1);
    push_valid = 1'b0;
    wait_sent(8'd9);
    wait_idle();
    check("t3_confs", conf_rises - c0, 5);
    check("t3_w0", dlog[q0], 1);
    check("t3_w1", dlog[q0+1], 6);
    check("t3_w4", dlog[q0+4], 9);
    check("t3_sent", sent_cnt, 9);

    // Echo mismatch is sticky.
    mask = 4'h1;
    push_word(4'h5);
    wait_sent(8'd10);
    check("t4_err_set", err, 1);
    mask = 4'h0;
    push_word(4'h6);
    wait_sent(8'd11);
    check("t4_err_sticky", err, 1);
    wait_idle();

    // Asynchronous reset while confirm is high.
    push_word(4'h2);
    push_word(4'h3);
    n = 0;
    while (confirm !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("t5_conf_high", confirm, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_confirm", confirm, 0);
    check("t5_req", req, 0);
    check("t5_din", din, 0);
    check("t5_sent", sent_cnt, 0);
    check("t5_err", err, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", push_ready, 1);
    tick();
    #2 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_post_req", req, 0);
    end

    // 256 words wrap the counter.
    c0 = conf_rises;
    for (int i = 0; i < 256; i++) begin
      push_word(4'(i));
    end
    wait_idle();
    check("t6_confs", conf_rises - c0, 256);
    check("t6_sent_wrap", sent_cnt, 0);
    check("t6_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_confirm_initiator.md
Name: req_confirm_initiator

Overview:
- Drives the req / din / confirm side of the lab request-confirm handshake toward the `system` responder. It acts as the transmitting end that feeds 4-bit words to that responder.
- Upstream logic pushes words into a small internal FIFO. The block raises `req`, presents each word on `din`, pulses `confirm` for a fixed hold time, then checks the echo on `dout_right`.
- The responder has no acknowledge output, so all phase lengths are parameterised cycle counts.

Parameters:
- DEPTH, 4, FIFO depth in words; power of two, 2..16.
- REQ_SETUP, 2, cycles `req` is high with `din`=0 before the first word.
- DATA_SETUP, 2, cycles `din` is stable before `confirm` rises.
- CONF_HOLD, 2, cycles `confirm` stays high.
- GAP, 1, cycles `req` is low after a burst before a new burst may start.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- push_valid, input, 1, upstream offers `push_data`.
- push_data, input, 4, word to transmit.
- push_ready, output, 1, `!full`; derived from the registered count.
- req, output, 1, request to responder.
- din, output, 4, data to responder.
- confirm, output, 1, confirm strobe to responder.
- dout_right, input, 4, responder echo of the confirmed word.
- busy, output, 1, FSM not in IDLE.
- sent_cnt, output, 8, words completed; wraps 255->0.
- err, output, 1, sticky echo mismatch.

Behaviour:
- Reset (async, any time, including mid-burst):
  - FIFO emptied; FSM forced to IDLE.
  - `req`=0, `din`=0, `confirm`=0, `busy`=0, `sent_cnt`=0, `err`=0, `push_ready`=1.
  - The word in flight is discarded; no partial `confirm` pulse survives reset.
- All outputs are registered. `req`/`din`/`confirm` are decoded from registered state plus the word register, so they are glitch-free.
- FIFO:
  - A push is accepted on an edge with `push_valid && push_ready`.
  - When full, `push_ready`=0 even if a pop occurs the same cycle; no same-cycle pass-through.
  - Simultaneous push and pop when non-full leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states, each held for exactly the stated number of cycles by a down-counter:
  - IDLE: `req`=0, `din`=0. If count>0, go to REQ on the next edge. A push at edge k gives `req`=1 after edge k+1.
  - REQ (REQ_SETUP cycles): `req`=1, `din`=0. On exit, pop the FIFO head into the word register and go to DATA.
  - DATA (DATA_SETUP cycles): `req`=1, `din`=word, `confirm`=0. Then go to CONF.
  - CONF (CONF_HOLD cycles): `req`=1, `din`=word, `confirm`=1. Then go to CHECK.
  - CHECK (1 cycle): `req`=1, `din`=word, `confirm`=0.
    - Sample `dout_right`; if it differs from word, set `err`=1 (sticky until reset).
    - Increment `sent_cnt` regardless of match.
    - If FIFO count>0: pop the next word and go to DATA, with `req` staying high (back-to-back, no new REQ_SETUP).
    - Otherwise go to GAP.
  - GAP (GAP cycles): `req`=0, `din`=0. Then go to IDLE. A push during GAP is queued; it must not shorten GAP.
- `confirm` never rises while `din` is changing: `din` is updated only on entry to DATA.
- `busy`=1 in every state except IDLE.
- `sent_cnt` is an 8-bit modular counter.

Decomposition:
- Shared package `handshake_pkg`:
  - state enum (IDLE, REQ, DATA, CONF, CHECK, GAP);
  - WORD_W=4;
  - counter width, derived from the largest phase parameter.
- Sub-module `sync_fifo` (parameters DEPTH, WIDTH):
  - registered count; `full`/`empty` flags; pop returns the head on the same edge.
  - Reusable by a later receive-side buffer.

Test Plan:
- Single word: reset, then push 4'h3, `dout_right` tied 4'h3.
  -> `req` high 1 cycle after push; `din`=0 for 2 cycles, then 3 for 2 cycles; `confirm` high 2 cycles; `sent_cnt`=1, `err`=0; `req` low 1 cycle later; `busy`=0.
- Burst: push 3, 5, 4 back-to-back, echo correct.
  -> single `req` high interval; three `confirm` pulses with `din` 3, 5, 4; no REQ phase between words; `sent_cnt`=3.
- Full FIFO: push 5 words with FSM stalled in REQ.
  -> `push_ready`=0 after the 4th word; 5th word not accepted; only 4 `confirm` pulses; `sent_cnt`=4.
- Mismatch: push 5, `dout_right`=4.
  -> `err`=1 after CHECK and stays 1 through a following correct word; `sent_cnt`=2.
- Reset mid-CONF: assert `rst` while `confirm`=1.
  -> `confirm`, `req`, `din` drop immediately (async); `sent_cnt`=0; FIFO empty. After release with no push, `req` stays 0.
- Wrap: send 256 words with correct echo.
  -> `sent_cnt` returns to 0; `err`=0.
